// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift_pipe barrel shifter:
//   - shift_mode_t   : 3-bit operation code
//   - SHIFT_*        : operation code constants (codes 5..7 are reserved and
//                      pass the operand through unchanged)
//   - shift_amnt_w   : width of the shift-amount field for a given data width
//   - stage_of       : which pipeline stage a shift level belongs to
//   - last_level     : highest shift level placed in a given stage
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef logic [2:0] shift_mode_t;

  localparam shift_mode_t SHIFT_SLL = 3'd0;  // logical left, zero fill from LSB
  localparam shift_mode_t SHIFT_SRL = 3'd1;  // logical right, zero fill from MSB
  localparam shift_mode_t SHIFT_SRA = 3'd2;  // arithmetic right, sign fill
  localparam shift_mode_t SHIFT_ROL = 3'd3;  // rotate left
  localparam shift_mode_t SHIFT_ROR = 3'd4;  // rotate right

  function automatic int shift_amnt_w(input int width);
    return $clog2(width);
  endfunction

  // Level k lives in stage floor(k * stages / levels). With stages <= levels
  // the mapping is monotonic and covers every stage at least once.
  function automatic int stage_of(input int level, input int stages, input int levels);
    return (level * stages) / levels;
  endfunction

  function automatic int last_level(input int stage, input int stages, input int levels);
    int last;
    last = 0;
    for (int k = 0; k < levels; k++) begin
      if (stage_of(k, stages, levels) == stage) last = k;
    end
    return last;
  endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational level of the barrel shifter. When enabled it moves the
// word by exactly DIST bit positions in the direction and with the fill the
// mode selects. Reserved modes, and a disabled level, pass data through.
//
// Parameters:
//   WIDTH  data width
//   DIST   shift distance of this level (a power of two, < WIDTH)
// Ports:
//   i_data  operand / partial result from the previous level
//   i_en    amount bit for this level
//   i_mode  operation code (shift_mode_t)
//   i_sign  sign bit captured when the request was accepted (SRA fill)
//   o_data  partial result
// -----------------------------------------------------------------------------
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  shift_mode_t      i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    // NOTE: o_data gets a value before any branch so no path leaves it
    // unassigned; without this default the block would infer a latch.
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        SHIFT_SLL: o_data = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHIFT_SRL: o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
        // Fill comes from the carried sign, never from partial data: after an
        // earlier level the MSB of the partial word is already a fill bit.
        SHIFT_SRA: o_data = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};
        SHIFT_ROL: o_data = {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
        SHIFT_ROR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        default:   o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Pipelined multi-mode barrel shifter (SLL, SRL, SRA, ROL, ROR) for the
// execute stage. The $clog2(WIDTH) shift levels are spread over STAGES
// register stages; latency equals STAGES, throughput is one result per cycle.
// The whole pipe advances as one unit: when the consumer stalls a valid
// result, every stage holds, bubbles included.
//
// Parameters:
//   WIDTH   data width, power of two, 4..64
//   STAGES  register stages, 1..$clog2(WIDTH)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request accepted when in_valid && in_ready
//   in_data    operand
//   in_amnt    shift distance, unsigned
//   in_mode    operation code (shift_pkg constants, 5..7 pass-through)
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   result
// Optional (macro SHIFT_PIPE_FLAGS_EN):
//   out_zero   1 iff out_data == 0
//   out_neg    out_data[WIDTH-1]
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [shift_amnt_w(WIDTH)-1:0] in_amnt,
  input  shift_mode_t                    in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data
`ifdef SHIFT_PIPE_FLAGS_EN
  ,
  output logic                           out_zero,
  output logic                           out_neg
`endif
);

  localparam int AMNT_W = shift_amnt_w(WIDTH);
  localparam int LEVELS = AMNT_W;

  // Everything a request carries between stages. The amount travels whole;
  // each stage only consumes the bits of the levels it owns.
  typedef struct packed {
    logic              valid;
    shift_mode_t       mode;
    logic              sign;
    logic [AMNT_W-1:0] amnt;
    logic [WIDTH-1:0]  data;
  } stage_t;

  stage_t           r_stage   [STAGES];  // stage output registers
  stage_t           w_src     [STAGES];  // what feeds the levels of each stage
  stage_t           w_next    [STAGES];  // next value of each stage register
  logic [WIDTH-1:0] w_lvl_out [LEVELS];  // output of each shift level
  logic             w_advance;

  // The pipe moves whenever the final register is empty or being drained.
  assign w_advance = out_ready || !r_stage[STAGES-1].valid;
  assign in_ready  = w_advance;

  // Stage 0 is fed from the input port; the sign is sampled here once and
  // carried with the request.
  assign w_src[0] = '{valid: in_valid,
                      mode:  in_mode,
                      sign:  in_data[WIDTH-1],
                      amnt:  in_amnt,
                      data:  in_data};

  for (genvar s = 1; s < STAGES; s++) begin : g_src
    assign w_src[s] = r_stage[s-1];
  end

  // Shift levels. The first level of a stage reads its stage's source
  // register; every other level chains off the level before it.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int  ST    = stage_of(k, STAGES, LEVELS);
    localparam bit  FIRST = (k == 0) || (stage_of(k - 1, STAGES, LEVELS) != ST);

    logic [WIDTH-1:0] w_in;

    if (FIRST) begin : g_first
      assign w_in = w_src[ST].data;
    end else begin : g_chain
      assign w_in = w_lvl_out[k-1];
    end

    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .i_data (w_in),
      .i_en   (w_src[ST].amnt[k]),
      .i_mode (w_src[ST].mode),
      .i_sign (w_src[ST].sign),
      .o_data (w_lvl_out[k])
    );
  end

  // Each stage register captures the control fields it was fed plus the data
  // leaving the last level it owns.
  for (genvar s = 0; s < STAGES; s++) begin : g_next
    localparam int LAST = last_level(s, STAGES, LEVELS);

    assign w_next[s] = '{valid: w_src[s].valid,
                         mode:  w_src[s].mode,
                         sign:  w_src[s].sign,
                         amnt:  w_src[s].amnt,
                         data:  w_lvl_out[LAST]};
  end

  // NOTE: the stage registers form a small array but are reset anyway:
  // in-flight requests must be discarded and out_data must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= '0;
      end
    end else if (w_advance) begin
      for (int s = 0; s < STAGES; s++) begin
        // NOTE: non-blocking so every stage loads its predecessor's old
        // value; blocking would push one request through all stages at once.
        r_stage[s] <= w_next[s];
      end
    end
  end

  assign out_valid = r_stage[STAGES-1].valid;
  assign out_data  = r_stage[STAGES-1].data;

`ifdef SHIFT_PIPE_FLAGS_EN
  // Flags follow the final register, so they are stable with out_data and
  // out_zero reads 1 while the pipe is in reset.
  assign out_zero = (r_stage[STAGES-1].data == '0);
  assign out_neg  = r_stage[STAGES-1].data[WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
// Self-checking bench for shift_pipe. Two instances run side by side:
// WIDTH=16/STAGES=2 (directed vectors, stall, mid-flight reset, random mix)
// and WIDTH=32/STAGES=5 (sweep of every mode and amount with random data and
// random back-pressure). Expected results come from an arithmetic reference
// model; a scoreboard checks order, latency, hold-while-stalled and in_ready.
// Optional flags are checked when SHIFT_PIPE_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_shift_pipe;
  import shift_pkg::*;

  typedef struct {
    logic [63:0] exp;
    int          t;
    int          ns;
  } item_t;

  logic clk;
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the shift written as plain word arithmetic on a w-bit value.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                            input int mode, input int w);
    logic [63:0] mask;
    logic [63:0] fill;
    logic        sgn;
    mask = (64'd1 << w) - 64'd1;
    d    = d & mask;
    sgn  = d[w-1];
    fill = mask & ~(mask >> amt);
    case (mode)
      SHIFT_SLL: return (d << amt) & mask;
      SHIFT_SRL: return d >> amt;
      SHIFT_SRA: return (d >> amt) | (sgn ? fill : 64'd0);
      SHIFT_ROL: return ((d << amt) | (d >> (w - amt))) & mask;
      SHIFT_ROR: return ((d >> amt) | (d << (w - amt))) & mask;
      default:   return d;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_blk
    localparam int W  = (g == 0) ? 16 : 32;
    localparam int S  = (g == 0) ? 2 : 5;
    localparam int AW = $clog2(W);

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amnt;
    shift_mode_t   in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef SHIFT_PIPE_FLAGS_EN
    logic          out_zero;
    logic          out_neg;
`endif

    logic [63:0] cur_exp;
    logic        done;
    logic        stop;
    item_t       q[$];
    item_t       it;
    int          cyc;
    int          nstall;
    logic        prev_hold;
    logic [W-1:0] prev_data;

    shift_pipe #(
      .WIDTH  (W),
      .STAGES (S)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amnt   (in_amnt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SHIFT_PIPE_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
    );

    // Scoreboard, evaluated mid-cycle on the falling edge.
    initial begin
      cyc = 0;
      nstall = 0;
      prev_hold = 1'b0;
      prev_data = '0;
    end

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        q.delete();
        prev_hold = 1'b0;
      end else begin
        check("in_ready_rule", in_ready, out_ready || !out_valid);
        if (prev_hold) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
          end else begin
            it = q.pop_front();
            check("data", out_data, it.exp);
            check("latency", cyc - it.t, S + (nstall - it.ns));
`ifdef SHIFT_PIPE_FLAGS_EN
            check("out_zero", out_zero, it.exp == 64'd0);
            check("out_neg", out_neg, it.exp[W-1]);
`endif
          end
        end
        if (in_valid && in_ready) begin
          q.push_back('{exp: cur_exp, t: cyc, ns: nstall});
        end
        if (!(out_ready || !out_valid)) nstall++;
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end

    // Present one request and return just after the edge that accepts it.
    task automatic send(input logic [63:0] d, input int a, input int m, input logic [63:0] e);
      int n;
      in_data  = W'(d);
      in_amnt  = AW'(a);
      in_mode  = 3'(m);
      cur_exp  = e;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (!in_ready) check("send_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
    endtask

    task automatic send_rand(input int m, input int a);
      logic [63:0] d;
      d = {$urandom, $urandom};
      send(d, a, m, ref_shift(d, a, m, W));
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("drain_empty", q.size(), 0);
    endtask

    task automatic reset_start();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amnt   = '0;
      in_mode   = SHIFT_SLL;
      out_ready = 1'b1;
      cur_exp   = '0;
      done      = 1'b0;
      stop      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1'b1);
`ifdef SHIFT_PIPE_FLAGS_EN
      check("rst_out_zero", out_zero, 1'b1);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    endtask

    // Random traffic with random idle gaps and random consumer back-pressure.
    task automatic random_phase(input int n_req, input bit sweep);
      stop = 1'b0;
      fork
        begin
          if (sweep) begin
            for (int m = 0; m < 8; m++) begin
              for (int a = 0; a < W; a++) begin
                send_rand(m, a);
                if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
                end
              end
            end
          end else begin
            repeat (n_req) begin
              send_rand($urandom_range(0, 7), $urandom_range(0, W - 1));
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
              end
            end
          end
          stop = 1'b1;
        end
        begin
          while (!stop) begin
            @(posedge clk);
            #1 out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
      drain();
    endtask

    if (g == 0) begin : g_drv16
      initial begin
        reset_start();

        // Directed vectors with literal expectations.
        send(64'h8421, 4,  SHIFT_SRA, 64'hF842);
        send(64'h8421, 4,  SHIFT_SRL, 64'h0842);
        send(64'h1234, 4,  SHIFT_ROR, 64'h4123);
        send(64'h1234, 4,  SHIFT_ROL, 64'h2341);
        send(64'hFFFF, 15, SHIFT_SLL, 64'h8000);
        send(64'h8000, 15, SHIFT_SRL, 64'h0001);
        send(64'h8000, 15, SHIFT_SRA, 64'hFFFF);
        send(64'h0001, 15, SHIFT_ROL, 64'h8000);
        send(64'hBEEF, 5,  6,         64'hBEEF);
        for (int m = 0; m < 8; m++) begin
          send(64'hA5C3 ^ 64'(m), 0, m, 64'hA5C3 ^ 64'(m));
        end
        drain();

        // Eight back-to-back requests with a three-cycle consumer stall.
        fork
          begin
            for (int i = 0; i < 8; i++) send_rand(i % 5, $urandom_range(0, 15));
          end
          begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join
        drain();

        // Reset with two requests in flight.
        send(64'h1357, 3, SHIFT_SLL, 64'h9AB8);
        send(64'h2468, 2, SHIFT_SRL, 64'h091A);
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(64'hC001, 1, SHIFT_ROR, 64'hE000);
        drain();

        random_phase(150, 1'b0);
        done = 1'b1;
      end
    end else begin : g_drv32
      initial begin
        reset_start();
        send(64'h0000_0001, 1, SHIFT_SRL, 64'h0000_0000);
        send(64'h8000_0000, 3, SHIFT_SRA, 64'hF000_0000);
        drain();
        random_phase(0, 1'b1);
        done = 1'b1;
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    #1;
    for (int i = 0; i < 60000 && !(g_blk[0].done === 1'b1 && g_blk[1].done === 1'b1); i++) begin
      @(posedge clk);
    end
    check("all_done", {g_blk[1].done, g_blk[0].done}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
